// File: rtl/arranque_pkg.sv
// arranque_pkg
// Shared types and helpers for the soft-start ramp controller.
//   arr_state_t : controller state encoding
//   arr_mode_t  : ramp-up dwell mode (slow / fast)
//   level_scale : step index -> drive level, floor(step*(2^level_w-1)/num_steps)
package arranque_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_FULL      = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } arr_state_t;

  typedef enum logic {
    MODE_SLOW = 1'b0,
    MODE_FAST = 1'b1
  } arr_mode_t;

  // 64-bit arithmetic so the product never overflows for practical widths.
  function automatic longint unsigned level_scale(input longint unsigned step,
                                                  input longint unsigned level_w,
                                                  input longint unsigned num_steps);
    longint unsigned full_scale;
    full_scale = (64'd1 << level_w) - 64'd1;
    return (step * full_scale) / num_steps;
  endfunction

endpackage

// File: rtl/rampa_dwell_cnt.sv
// rampa_dwell_cnt
// Per-step dwell timer. Counts cycles spent on the current step and flags the
// last cycle of the dwell.
//   clk    : clock
//   reset  : synchronous active-low reset
//   clear  : restart the count at zero on the next edge (step entry)
//   en     : count this cycle
//   limit  : number of cycles a step is held (>= 1)
//   done   : high during the final cycle of the dwell
module rampa_dwell_cnt #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               en,
  input  logic [DWELL_W-1:0] limit,
  output logic               done
);

  logic [DWELL_W-1:0] cnt;

  // Saturates at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + DWELL_W'(1);
    end
  end

  // cnt is 0 on the first cycle of a step, so limit-1 marks the last one.
  assign done = en && (cnt >= (limit - DWELL_W'(1)));

endmodule

// File: rtl/arranque_rampa_param.sv
// arranque_rampa_param
// Soft-start ramp controller: steps an output level up to full scale in fast
// or slow increments, holds it, and ramps it back down on a stop request.
//   clk     : clock
//   reset   : synchronous active-low reset
//   Rapido  : start/continue ramp-up, fast dwell
//   Lento   : start/continue ramp-up, slow dwell
//   Parar   : stop request, ramps down to zero (highest priority)
//   step    : current step index, 0 = off
//   level   : drive level scaled from step
//   ramping : high while ramping up or down
//   at_full : high in FULL
//
// state        | meaning
// ST_IDLE      | output off, step = 0
// ST_RAMP_UP   | stepping up, dwell from latched mode
// ST_FULL      | step = NUM_STEPS, held until Parar
// ST_RAMP_DOWN | stepping down, fast dwell
module arranque_rampa_param
  import arranque_pkg::*;
#(
  parameter int NUM_STEPS  = 4,
  parameter int LEVEL_W    = 8,
  parameter int DWELL_W    = 16,
  parameter int DWELL_FAST = 2,
  parameter int DWELL_SLOW = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           Rapido,
  input  logic                           Lento,
  input  logic                           Parar,
  output logic [$clog2(NUM_STEPS+1)-1:0] step,
  output logic [LEVEL_W-1:0]             level,
  output logic                           ramping,
  output logic                           at_full
);

  localparam int                 SW       = $clog2(NUM_STEPS + 1);
  localparam logic [SW-1:0]      STEP_MAX = SW'(NUM_STEPS);
  localparam logic [DWELL_W-1:0] LIM_FAST = DWELL_W'(DWELL_FAST);
  localparam logic [DWELL_W-1:0] LIM_SLOW = DWELL_W'(DWELL_SLOW);

  if (NUM_STEPS < 2) begin : g_chk_steps
    $error("NUM_STEPS must be at least 2");
  end
  if ((DWELL_FAST < 1) || (DWELL_SLOW < 1)) begin : g_chk_dwell_min
    $error("DWELL_FAST and DWELL_SLOW must be at least 1");
  end
  if (((DWELL_FAST >> DWELL_W) != 0) || ((DWELL_SLOW >> DWELL_W) != 0)) begin : g_chk_dwell_fit
    $error("DWELL_FAST/DWELL_SLOW do not fit in DWELL_W bits");
  end

  arr_state_t         state_q, state_n;
  arr_mode_t          mode_q, mode_n, mode_sel;
  logic [SW-1:0]      step_q, step_n;
  logic               dwell_clr, dwell_en, dwell_done, go;
  logic [DWELL_W-1:0] dwell_lim;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      mode_q  <= MODE_SLOW;
    end else begin
      state_q <= state_n;
      step_q  <= step_n;
      mode_q  <= mode_n;
    end
  end

  assign go       = (Rapido || Lento) && !Parar;
  assign mode_sel = Rapido ? MODE_FAST : (Lento ? MODE_SLOW : mode_q);
  assign dwell_en = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
  assign dwell_lim = ((state_q == ST_RAMP_DOWN) || (mode_q == MODE_FAST)) ? LIM_FAST : LIM_SLOW;

  rampa_dwell_cnt #(
    .DWELL_W (DWELL_W)
  ) u_dwell (
    .clk   (clk),
    .reset (reset),
    .clear (dwell_clr),
    .en    (dwell_en),
    .limit (dwell_lim),
    .done  (dwell_done)
  );

  // Next-state logic
  always_comb begin
    state_n   = state_q;
    step_n    = step_q;
    mode_n    = mode_q;
    dwell_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_n   = ST_RAMP_UP;
          step_n    = SW'(1);
          mode_n    = mode_sel;
          dwell_clr = 1'b1;
        end
      end
      ST_RAMP_UP: begin
        if (Parar) begin
          state_n   = ST_RAMP_DOWN;
          dwell_clr = 1'b1;
        end else if (dwell_done) begin
          step_n    = step_q + SW'(1);
          mode_n    = mode_sel;
          dwell_clr = 1'b1;
          if ((step_q + SW'(1)) == STEP_MAX) state_n = ST_FULL;
        end
      end
      ST_FULL: begin
        if (Parar) begin
          state_n   = ST_RAMP_DOWN;
          dwell_clr = 1'b1;
        end
      end
      ST_RAMP_DOWN: begin
        if (go) begin
          // Resuming at the top step means there is nothing left to climb.
          state_n   = (step_q == STEP_MAX) ? ST_FULL : ST_RAMP_UP;
          mode_n    = mode_sel;
          dwell_clr = 1'b1;
        end else if (dwell_done) begin
          step_n    = step_q - SW'(1);
          dwell_clr = 1'b1;
          if (step_q == SW'(1)) state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        step_n  = '0;
      end
    endcase
  end

  // Output decode
  always_comb begin
    ramping = 1'b0;
    at_full = 1'b0;
    unique case (state_q)
      ST_RAMP_UP, ST_RAMP_DOWN: ramping = 1'b1;
      ST_FULL:                  at_full = 1'b1;
      default: ;
    endcase
  end

  assign step  = step_q;
  assign level = LEVEL_W'(level_scale(64'(step_q), 64'(LEVEL_W), 64'(NUM_STEPS)));

endmodule

// File: tb/tb_arranque_rampa_param.sv
module tb_arranque_rampa_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rapido = 1'b0, lento = 1'b0, parar = 1'b0;
  logic [2:0] step;
  logic [7:0] level;
  logic       ramping, at_full;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic rst;
    logic r;
    logic l;
    logic p;
    int   st;
    int   ramp;
    int   full;
  } vec_t;

  vec_t vecs[$];
  int   lvl_of[5] = '{0, 63, 127, 191, 255};

  always #5 clk = ~clk;

  arranque_rampa_param #(
    .NUM_STEPS  (4),
    .LEVEL_W    (8),
    .DWELL_W    (16),
    .DWELL_FAST (2),
    .DWELL_SLOW (5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .Rapido  (rapido),
    .Lento   (lento),
    .Parar   (parar),
    .step    (step),
    .level   (level),
    .ramping (ramping),
    .at_full (at_full)
  );

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int st, input int ramp, input int full);
    chk({tag, " step"},    int'(step),    st);
    chk({tag, " level"},   int'(level),   lvl_of[st]);
    chk({tag, " ramping"}, int'(ramping), ramp);
    chk({tag, " at_full"}, int'(at_full), full);
  endtask

  task automatic tick(input logic rst, input logic r, input logic l, input logic p);
    reset  = rst;
    rapido = r;
    lento  = l;
    parar  = p;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic rst, input logic r, input logic l, input logic p,
                              input int st, input int ramp, input int full);
    vec_t v;
    v = '{rst, r, l, p, st, ramp, full};
    vecs.push_back(v);
  endfunction

  task automatic go_idle(input string tag);
    int n = 0;
    tick(1, 0, 0, 1);
    while (((step != 3'd0) || ramping) && (n < 20)) begin
      tick(1, 0, 0, 0);
      n++;
    end
    chk({tag, " idle_reached"}, int'(n < 20), 1);
    chk_out({tag, " idle"}, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset held: inputs ignored
    add(0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    // Rapido pulse: 63,63,127,127,191,191,255
    add(1, 1, 0, 0, 1, 1, 0);
    add(1, 0, 0, 0, 1, 1, 0);
    add(1, 0, 0, 0, 2, 1, 0);
    add(1, 0, 0, 0, 2, 1, 0);
    add(1, 0, 0, 0, 3, 1, 0);
    add(1, 0, 0, 0, 3, 1, 0);
    add(1, 0, 0, 0, 4, 0, 1);
    add(1, 0, 0, 0, 4, 0, 1);
    add(1, 0, 0, 0, 4, 0, 1);
    // Parar in FULL: 255 x2 then down to idle
    add(1, 0, 0, 1, 4, 1, 0);
    add(1, 0, 0, 0, 4, 1, 0);
    add(1, 0, 0, 0, 3, 1, 0);
    add(1, 0, 0, 0, 3, 1, 0);
    add(1, 0, 0, 0, 2, 1, 0);
    add(1, 0, 0, 0, 2, 1, 0);
    add(1, 0, 0, 0, 1, 1, 0);
    add(1, 0, 0, 0, 1, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    // Parar in IDLE, alone or with a start request: no effect
    add(1, 0, 0, 1, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 0);
    add(1, 0, 1, 1, 0, 0, 0);
    // Rapido and Lento together: fast steps
    add(1, 1, 1, 0, 1, 1, 0);
    add(1, 1, 1, 0, 1, 1, 0);
    add(1, 1, 1, 0, 2, 1, 0);
    add(1, 1, 1, 0, 2, 1, 0);
    add(1, 1, 1, 0, 3, 1, 0);
    add(1, 1, 1, 0, 3, 1, 0);
    add(1, 1, 1, 0, 4, 0, 1);
    add(1, 1, 1, 0, 4, 0, 1);
    add(1, 1, 1, 1, 4, 1, 0);
    add(1, 0, 0, 1, 4, 1, 0);
    add(1, 0, 0, 1, 3, 1, 0);
    add(1, 0, 0, 1, 3, 1, 0);
    add(1, 0, 0, 1, 2, 1, 0);
    add(1, 0, 0, 1, 2, 1, 0);
    add(1, 0, 0, 1, 1, 1, 0);
    add(1, 0, 0, 1, 1, 1, 0);
    add(1, 0, 0, 1, 0, 0, 0);
    // Lento start, Rapido at step 2 entry: step 1 x5, steps 2-3 x2
    add(1, 0, 1, 0, 1, 1, 0);
    add(1, 0, 0, 0, 1, 1, 0);
    add(1, 0, 0, 0, 1, 1, 0);
    add(1, 0, 0, 0, 1, 1, 0);
    add(1, 0, 0, 0, 1, 1, 0);
    add(1, 1, 0, 0, 2, 1, 0);
    add(1, 0, 0, 0, 2, 1, 0);
    add(1, 0, 0, 0, 3, 1, 0);
    add(1, 0, 0, 0, 3, 1, 0);
    add(1, 0, 0, 0, 4, 0, 1);

    foreach (vecs[i]) begin
      tick(vecs[i].rst, vecs[i].r, vecs[i].l, vecs[i].p);
      chk_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].ramp, vecs[i].full);
    end

    // Stop from FULL, Parar+Rapido at step 3 keeps going down, Rapido alone at step 2 resumes
    tick(1, 0, 0, 1); chk_out("res_a", 4, 1, 0);
    tick(1, 0, 0, 0); chk_out("res_b", 4, 1, 0);
    tick(1, 0, 0, 0); chk_out("res_c", 3, 1, 0);
    tick(1, 1, 0, 1); chk_out("res_d", 3, 1, 0);
    tick(1, 1, 0, 1); chk_out("res_e", 2, 1, 0);
    tick(1, 1, 0, 0); chk_out("res_f", 2, 1, 0);
    tick(1, 0, 0, 0); chk_out("res_g", 2, 1, 0);
    tick(1, 0, 0, 0); chk_out("res_h", 3, 1, 0);
    tick(1, 0, 0, 0); chk_out("res_i", 3, 1, 0);
    tick(1, 0, 0, 0); chk_out("res_j", 4, 0, 1);
    go_idle("res_down");

    // Lento held: 15 cycles at 63/127/191, then full
    for (int i = 0; i < 15; i++) begin
      tick(1, 0, 1, 0);
      chk_out($sformatf("lento%0d", i), 1 + i / 5, 1, 0);
    end
    tick(1, 0, 1, 0); chk_out("lento_full", 4, 0, 1);
    go_idle("lento_down");

    // Reset mid ramp-up at step 2
    tick(1, 1, 0, 0); chk_out("rst_a", 1, 1, 0);
    tick(1, 0, 0, 0); chk_out("rst_b", 1, 1, 0);
    tick(1, 0, 0, 0); chk_out("rst_c", 2, 1, 0);
    tick(0, 1, 0, 0); chk_out("rst_d", 0, 0, 0);
    tick(1, 0, 0, 0); chk_out("rst_e", 0, 0, 0);
    tick(1, 0, 0, 1); chk_out("rst_f", 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arranque_rampa_param.md
ARRANQUE_RAMPA_PARAM -- requirements
Module: arranque_rampa_param

Interface
REQ-001 SHALL have parameter NUM_STEPS, default 4, number of non-zero ramp steps (>=2).
REQ-002 SHALL have parameter LEVEL_W, default 8, width of output level.
REQ-003 SHALL have parameter DWELL_W, default 16, width of dwell counter.
REQ-004 SHALL have parameter DWELL_FAST, default 2, cycles held per step in fast mode and in ramp-down (>=1).
REQ-005 SHALL have parameter DWELL_SLOW, default 5, cycles held per step in slow mode (>=1).
REQ-006 clk  input  1  sole clock, all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-low reset.
REQ-008 Rapido  input  1  start/continue ramp-up in fast mode.
REQ-009 Lento  input  1  start/continue ramp-up in slow mode.
REQ-010 Parar  input  1  stop request, ramps output down to zero.
REQ-011 step  output  $clog2(NUM_STEPS+1)  current step index, 0 = off.
REQ-012 level  output  LEVEL_W  drive level = floor(step*(2^LEVEL_W-1)/NUM_STEPS).
REQ-013 ramping  output  1  high in RAMP_UP or RAMP_DOWN.
REQ-014 at_full  output  1  high only in FULL state.

Function
REQ-015 SHALL implement states IDLE, RAMP_UP, FULL, RAMP_DOWN.
REQ-016 IDLE: step=0; Rapido or Lento (Parar low) sampled high -> next cycle RAMP_UP with step=1, dwell counter cleared.
REQ-017 Mode SHALL be latched at each step entry: Rapido high -> fast; else Lento high -> slow; neither -> keep previous mode; Rapido wins if both high.
REQ-018 RAMP_UP: step SHALL be held exactly the latched mode's dwell cycles, then increment; reaching step=NUM_STEPS -> FULL in the same cycle.
REQ-019 FULL: step=NUM_STEPS held indefinitely until Parar.
REQ-020 Parar high in RAMP_UP or FULL -> next cycle RAMP_DOWN, step unchanged, dwell counter cleared.
REQ-021 RAMP_DOWN: step SHALL be held DWELL_FAST cycles then decrement; step reaching 0 -> IDLE in the same cycle.
REQ-022 Rapido or Lento high with Parar low during RAMP_DOWN -> next cycle RAMP_UP from current step, dwell counter cleared, mode re-latched.
REQ-023 Parar SHALL take priority over Rapido/Lento in every state; Parar in IDLE has no effect.
REQ-024 level SHALL be combinational from step only; no extra latency versus step.
REQ-025 Dwell counter SHALL saturate, never wrap; DWELL_FAST/DWELL_SLOW SHALL fit in DWELL_W (elaboration check).

Reset
REQ-026 reset low at a rising edge SHALL force IDLE, step=0, level=0, ramping=0, at_full=0, dwell counter=0, mode=slow, from any state including mid-ramp.
REQ-027 Inputs SHALL be ignored in any cycle reset is low.

Structure
REQ-028 State enum and level-scaling function SHALL live in shared package arranque_pkg.
REQ-029 Dwell counter SHALL be sub-module rampa_dwell_cnt (clear, load limit, done pulse).
REQ-030 Single next-state process plus registered state/step/mode; outputs decoded from registers.

Verification (NUM_STEPS=4, LEVEL_W=8, DWELL_FAST=2, DWELL_SLOW=5)
REQ-031 Rapido pulse in IDLE -> level 63,63,127,127,191,191,255 then at_full=1 held.
REQ-032 Lento held in IDLE -> each of 63/127/191 held 5 cycles, then 255, at_full=1 after 15 cycles at non-zero level.
REQ-033 Parar in FULL -> 255 held 2 cycles then 191,191,127,127,63,63,0, IDLE, ramping=0.
REQ-034 Rapido and Lento together -> fast (2-cycle) steps; Lento then Rapido at step 2 entry -> step 1 held 5, steps 2-3 held 2.
REQ-035 Parar at step 3 in RAMP_DOWN then Rapido at step 2 -> RAMP_UP from 127, reaches 255; Parar+Rapido together -> ramp-down continues.
REQ-036 reset low mid-RAMP_UP at step 2 -> next cycle step=0, level=0, all flags 0; Parar in IDLE -> no change.
